// File: rtl/dfp_burst_arbiter.sv
// dfp_burst_arbiter: memory-side responder for the icache and dcache dfp ports.
// Arbitrates the two caches round-robin, turns each granted 256-bit line
// request into a 4-beat bmem burst, assembles returning read beats and pulses
// the granted cache's resp for one cycle. miss_times counts icache requests
// that lost arbitration at least once.
//
// Handshake: a cache holds its request level and address stable until it sees
// its resp pulse and drops it at that same edge; bmem_read / bmem_write are
// presented continuously and a command or beat is taken only in a cycle with
// bmem_ready=1; read beats are taken on bmem_rvalid=1 with a matching tag.
module dfp_burst_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       dfp_addr,
    input  logic                        dfp_read,
    output logic [BEAT_WIDTH*BEATS-1:0] dfp_rdata,
    output logic                        dfp_resp,
    input  logic [ADDR_WIDTH-1:0]       dfp_daddr,
    input  logic                        dfp_dread,
    input  logic                        dfp_dwrite,
    input  logic [BEAT_WIDTH*BEATS-1:0] dfp_dwdata,
    output logic [BEAT_WIDTH*BEATS-1:0] dfp_drdata,
    output logic                        dfp_dresp,
    output logic [ADDR_WIDTH-1:0]       bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_WIDTH-1:0]       bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [ADDR_WIDTH-1:0]       bmem_raddr,
    input  logic [BEAT_WIDTH-1:0]       bmem_rdata,
    input  logic                        bmem_rvalid,
    output logic [31:0]                 miss_times
);

    localparam int LINE_W = BEAT_WIDTH * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((BEATS * BEAT_WIDTH / 8) - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CMD   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    // tie_d_q: the dcache wins the next tie. Set after an icache grant,
    // cleared after a dcache grant; out of reset the dcache wins the first tie.
    logic                    tie_d_q, tie_d_d;
    logic                    gnt_d_q, gnt_d_d;     // current transaction belongs to dcache
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic [LINE_W-1:0]       drdata_q, drdata_d;
    logic [31:0]             miss_q, miss_d;
    logic                    flag_q, flag_d;       // current icache request already counted

    logic                    i_pend, d_pend, grant_d;
    logic                    last_beat;
    logic [LINE_W-1:0]       line_ins;
    logic [BEAT_WIDTH-1:0]   wbeat;

    // Beat-indexed datapath: line with the incoming read beat inserted, and the outgoing write beat.
    always_comb begin
        line_ins = line_q;
        wbeat    = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_q == CNT_W'(k)) begin
                line_ins[k*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
                wbeat = line_q[k*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Next-state, arbitration, beat counting and miss accounting.
    always_comb begin
        state_d  = state_q;
        tie_d_d  = tie_d_q;
        gnt_d_d  = gnt_d_q;
        addr_d   = addr_q;
        line_d   = line_q;
        beat_d   = beat_q;
        rdata_d  = rdata_q;
        drdata_d = drdata_q;
        miss_d   = miss_q;
        flag_d   = flag_q;
        i_pend   = dfp_read;
        d_pend   = dfp_dread | dfp_dwrite;
        grant_d  = d_pend && (!i_pend || tie_d_q);
        last_beat = (beat_q == CNT_W'(BEATS - 1));

        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    gnt_d_d = grant_d;
                    tie_d_d = !grant_d;
                    beat_d  = '0;
                    if (grant_d) begin
                        addr_d = dfp_daddr & ~LINE_MASK;
                        // A simultaneous read and write is illegal; the write wins.
                        if (dfp_dwrite) begin
                            line_d  = dfp_dwdata;
                            state_d = WR_BURST;
                        end else begin
                            state_d = RD_CMD;
                        end
                        if (dfp_read && !flag_q) begin
                            flag_d = 1'b1;
                            if (miss_q != 32'hFFFF_FFFF) begin
                                miss_d = miss_q + 32'd1;
                            end
                        end
                    end else begin
                        addr_d  = dfp_addr & ~LINE_MASK;
                        state_d = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (bmem_ready) begin
                    beat_d  = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Beats tagged with another address are stragglers and are dropped.
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    line_d = line_ins;
                    if (last_beat) begin
                        state_d = RESP;
                        if (gnt_d_q) begin
                            drdata_d = line_ins;
                        end else begin
                            rdata_d = line_ins;
                        end
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (last_beat) begin
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!gnt_d_q) begin
                    flag_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tie_d_q  <= 1'b1;
            gnt_d_q  <= 1'b0;
            addr_q   <= '0;
            line_q   <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            drdata_q <= '0;
            miss_q   <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tie_d_q  <= tie_d_d;
            gnt_d_q  <= gnt_d_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            drdata_q <= drdata_d;
            miss_q   <= miss_d;
            flag_q   <= flag_d;
        end
    end

    assign bmem_read  = (state_q == RD_CMD);
    assign bmem_write = (state_q == WR_BURST);
    assign bmem_addr  = addr_q;
    assign bmem_wdata = (state_q == WR_BURST) ? wbeat : '0;
    assign dfp_resp   = (state_q == RESP) && !gnt_d_q;
    assign dfp_dresp  = (state_q == RESP) && gnt_d_q;
    assign dfp_rdata  = rdata_q;
    assign dfp_drdata = drdata_q;
    assign miss_times = miss_q;

endmodule
